// File: rtl/track_sequencer.sv
// track_sequencer
//   Current-track controller for the music player. Holds the index of the
//   playing track and moves it on next/prev button release, on end-of-track,
//   or on a direct jump, following the selected play mode.
//
// Parameters
//   TRACK_W     width of the track index (2^(TRACK_W-1) < NUM_TRACKS <= 2^TRACK_W)
//   NUM_TRACKS  number of stored tracks; valid indices 0..NUM_TRACKS-1
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   next_btn    debounced level, acts on release
//   prev_btn    debounced level, acts on release
//   track_end   one-cycle pulse when the current track finishes
//   mode        00 wrap, 01 repeat-one, 10 play-once, 11 shuffle
//   jump_valid  load jump_idx as the current track
//   jump_idx    requested track index
//   select      current track index (upper score-memory address bits)
//   start       one-cycle pulse when a track (re)starts; held through reset
//   done        sticky: play-once finished the last track
//
// Build option
//   TRACK_SHUFFLE_EN  when defined, mode 11 picks a pseudo-random track from
//                     an 8-bit LFSR; when undefined, mode 11 behaves as 00.

module track_sequencer #(
  parameter int TRACK_W    = 2,
  parameter int NUM_TRACKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next_btn,
  input  logic               prev_btn,
  input  logic               track_end,
  input  logic [1:0]         mode,
  input  logic               jump_valid,
  input  logic [TRACK_W-1:0] jump_idx,
  output logic [TRACK_W-1:0] select,
  output logic               start,
  output logic               done
);

  localparam logic [TRACK_W-1:0] LAST_IDX = TRACK_W'(NUM_TRACKS - 1);
  // One bit wider so NUM_TRACKS == 2^TRACK_W still compares correctly.
  localparam logic [TRACK_W:0]   NUM_EXT  = (TRACK_W + 1)'(NUM_TRACKS);

  typedef enum logic [2:0] {
    IDLE, NEXT_HELD, PREV_HELD, ADVANCE, AUTO, RETREAT
  } state_t;

  state_t             state_q, state_d;
  logic [TRACK_W-1:0] select_q, select_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  // A button that is already held must be released before it can act again:
  // set for both buttons by reset, and for next when both are pressed together.
  logic               next_blk_q, next_blk_d;
  logic               prev_blk_q, prev_blk_d;

  logic [TRACK_W-1:0] inc_idx, dec_idx, shuf_idx;
  logic               jump_ok, prev_go, next_go;

  assign inc_idx = (select_q == LAST_IDX) ? '0 : select_q + TRACK_W'(1);
  assign dec_idx = (select_q == '0) ? LAST_IDX : select_q - TRACK_W'(1);
  assign jump_ok = {1'b0, jump_idx} < NUM_EXT;
  assign prev_go = prev_btn & ~prev_blk_q;
  assign next_go = next_btn & ~next_blk_q;

`ifdef TRACK_SHUFFLE_EN
  logic [7:0]         lfsr_q, lfsr_d;
  logic [TRACK_W-1:0] cand_raw, cand;

  // Fibonacci LFSR, taps 8,6,5,4; free-running every clock.
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand_raw = lfsr_q[TRACK_W-1:0];
  // cand_raw < 2*NUM_TRACKS, so one subtraction folds it into range.
  assign cand     = ({1'b0, cand_raw} >= NUM_EXT) ? cand_raw - TRACK_W'(NUM_TRACKS)
                                                  : cand_raw;
  // Never replay the track that just ended.
  assign shuf_idx = (cand == select_q) ? inc_idx : cand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign shuf_idx = inc_idx;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      select_q   <= '0;
      start_q    <= 1'b1;
      done_q     <= 1'b0;
      next_blk_q <= 1'b1;
      prev_blk_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      select_q   <= select_d;
      start_q    <= start_d;
      done_q     <= done_d;
      next_blk_q <= next_blk_d;
      prev_blk_q <= prev_blk_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    next_blk_d = next_btn & next_blk_q;
    prev_blk_d = prev_btn & prev_blk_q;
    case (state_q)
      IDLE: begin
        if (jump_valid) begin
          state_d = IDLE;
        end else if (track_end) begin
          state_d = AUTO;
        end else if (prev_go) begin
          state_d    = PREV_HELD;
          next_blk_d = next_btn;
        end else if (next_go) begin
          state_d = NEXT_HELD;
        end
      end
      NEXT_HELD: begin
        if (track_end) begin
          state_d = AUTO;
        end else if (!next_btn) begin
          state_d = ADVANCE;
        end
      end
      PREV_HELD: begin
        if (track_end) begin
          state_d = AUTO;
        end else if (!prev_btn) begin
          state_d = RETREAT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    select_d = select_q;
    start_d  = 1'b0;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (jump_valid && jump_ok) begin
          select_d = jump_idx;
          start_d  = 1'b1;
          done_d   = 1'b0;
        end
      end
      ADVANCE: begin
        select_d = inc_idx;
        start_d  = 1'b1;
        done_d   = 1'b0;
      end
      RETREAT: begin
        select_d = dec_idx;
        start_d  = 1'b1;
        done_d   = 1'b0;
      end
      AUTO: begin
        case (mode)
          2'b01: start_d = 1'b1;
          2'b10: begin
            if (select_q == LAST_IDX) begin
              done_d = 1'b1;
            end else begin
              select_d = inc_idx;
              start_d  = 1'b1;
              done_d   = 1'b0;
            end
          end
          2'b11: begin
            select_d = shuf_idx;
            start_d  = 1'b1;
            done_d   = 1'b0;
          end
          default: begin
            select_d = inc_idx;
            start_d  = 1'b1;
            done_d   = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign select = select_q;
  assign start  = start_q;
  assign done   = done_q;

endmodule

// File: doc/track_sequencer.md
# track_sequencer

Parametrised current-track controller for the music player. It holds the index of the track that is playing and moves it on the prev/next buttons, on end-of-track from the player, or on a direct jump. Behaviour follows a selectable play mode: wrap, repeat-one, play-once, or shuffle. Its `select` output forms the upper address bits of the score memory, and `start` restarts the note sequencer.

## Interface
- `TRACK_W`, 2: width of the track index. Must satisfy 2^(TRACK_W-1) < NUM_TRACKS <= 2^TRACK_W.
- `NUM_TRACKS`, 4: number of tracks stored in memory; valid indices are 0..NUM_TRACKS-1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `next_btn`  in  1  debounced level; acts on release.
- `prev_btn`  in  1  debounced level; acts on release.
- `track_end`  in  1  one-cycle pulse from the player when the current track finishes.
- `mode`  in  2  play mode: 00 wrap, 01 repeat-one, 10 play-once, 11 shuffle.
- `jump_valid`  in  1  load `jump_idx` as the current track.
- `jump_idx`  in  TRACK_W  requested track index.
- `select`  out  TRACK_W  current track index.
- `start`  out  1  high for one cycle when a track (re)starts.
- `done`  out  1  play-once has finished the last track; sticky.

## Operation
- Reset: `select`=0, `start`=1, `done`=0, state IDLE, LFSR=8'hA5.
- States: IDLE, NEXT_HELD, PREV_HELD, ADVANCE, AUTO, RETREAT.
- IDLE:
  - Clears `start` on every edge.
  - Input priority: `jump_valid` > `track_end` > `prev_btn` > `next_btn`.
  - Jump: if `jump_idx` < NUM_TRACKS, set `select`=`jump_idx`, `start`=1, `done`=0 on the same edge. Otherwise the jump is ignored.
  - `track_end` -> AUTO. `prev_btn` -> PREV_HELD. `next_btn` -> NEXT_HELD.
- NEXT_HELD: goes to ADVANCE when `next_btn`=0. PREV_HELD: goes to RETREAT when `prev_btn`=0.
- A `track_end` in either HELD state abandons the press and goes to AUTO. If the button is still held after that, it re-enters HELD and acts on its next release.
- ADVANCE (button next):
  - NUM_TRACKS-1 wraps to 0; otherwise `select`+1. This applies in every mode.
  - Sets `start`=1 and `done`=0, then goes to IDLE.
- RETREAT: 0 wraps to NUM_TRACKS-1; otherwise `select`-1. Sets `start`=1 and `done`=0, then goes to IDLE.
- AUTO (end of track), by mode:
  - 00: same as ADVANCE.
  - 01: `select` unchanged, `start`=1.
  - 10: below the last track, same as ADVANCE. At NUM_TRACKS-1: `select` unchanged, `start` stays 0, `done`=1.
  - 11: shuffle (see Configuration).
  - Every mode returns to IDLE.
- Index arithmetic is TRACK_W bits wide. Compare against NUM_TRACKS-1 explicitly; never rely on natural overflow.
- `mode` is sampled only in AUTO. A mode change mid-track takes effect at the next `track_end`.
- Reset mid-operation: any state goes to IDLE immediately with the reset values above. A pending press is discarded.

## Timing
- Button action:
  - Edge E0 samples the release and moves to ADVANCE/RETREAT.
  - Edge E1 updates `select` and sets `start`=1.
  - Edge E2 clears `start`.
  - `select` changes 2 cycles after release is sampled.
- `track_end`: sampled at E0 -> AUTO; `select`/`start` update at E1. Latency is 2 cycles.
- Jump: `select` and `start` update on the sampling edge. Latency is 1 cycle.
- `start` is never high for more than one cycle, except after reset: it is held from reset until the first edge after reset deasserts.
- Both buttons pressed together in IDLE: prev wins; next is ignored until it is released and pressed again.

## Configuration
- `TRACK_SHUFFLE_EN` defined:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting every clock.
  - In mode 11, AUTO computes a candidate: c = LFSR[TRACK_W-1:0], minus NUM_TRACKS if c >= NUM_TRACKS.
  - If c equals `select`, use the wrapped `select`+1 instead. Then set `start`=1.
  - Buttons stay sequential in shuffle mode.
- Not defined: no LFSR in hardware, and mode 11 behaves exactly as mode 00.

## Test plan
- Reset with NUM_TRACKS=4: `select`=0 and `start`=1 during reset, `start`=0 one edge after release. Press and release next 4 times: `select` goes 1,2,3,0, with one-cycle `start` pulses 2 cycles after each release.
- Prev from 0 with NUM_TRACKS=3, TRACK_W=2: `select`=2. Prev again: 1. Next from 2: 0. Index 3 never appears.
- Mode 10 with `select`=3: `track_end` -> `select`=3, no `start`, `done`=1. Then `jump_idx`=1: `select`=1, `start`=1, `done`=0. `jump_idx`=5 with TRACK_W=3, NUM_TRACKS=5: ignored.
- Mode 01 with `select`=2: `track_end` -> `select`=2, `start` pulses once at latency 2. `track_end` while next is held: `select` 2->3 (mode 00), then release of next -> 0.
- `TRACK_SHUFFLE_EN` defined, mode 11, 50 `track_end` pulses: each `select` < NUM_TRACKS and differs from the previous value. Without the macro: same stimulus gives the sequence 1,2,3,0,...
- Reset asserted while in NEXT_HELD: `select`=0 immediately. Releasing next after reset deasserts causes no change.
